// File: rtl/pp_gen_8x8.sv
// 8x8 unsigned multiplier front end: two-stage valid/ready pipeline producing four 4x4 partial products.
// Define PP_APPROX_EN to zero the APPROX_BITS LSBs of ll (approximate mode).
module pp_gen_8x8 #(
    parameter int unsigned APPROX_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] ll,
    output logic [7:0] lh,
    output logic [7:0] hl,
    output logic [7:0] hh
);

    localparam int unsigned AB_CLAMP =
        (APPROX_BITS < 1) ? 1 : ((APPROX_BITS > 4) ? 4 : APPROX_BITS);

`ifdef PP_APPROX_EN
    localparam logic [7:0] LL_MASK = 8'hFF << AB_CLAMP;
`else
    localparam logic [7:0] LL_MASK = 8'hFF | (8'hFF << AB_CLAMP);
`endif

    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        return {4'b0, x} * {4'b0, y};
    endfunction

    logic       s1_valid_q, s1_valid_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       s2_valid_q, s2_valid_d;
    logic [7:0] ll_q, ll_d;
    logic [7:0] lh_q, lh_d;
    logic [7:0] hl_q, hl_d;
    logic [7:0] hh_q, hh_d;

    logic s2_ready;
    logic s1_adv;
    logic in_fire;

    // in_ready depends only on stage state and out_ready, never on in_valid
    always_comb begin
        s2_ready = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_ready;
        in_ready = !s1_valid_q || s2_ready;
        in_fire  = in_valid && in_ready;
    end

    always_comb begin
        s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
        a_d        = in_fire ? a : a_q;
        b_d        = in_fire ? b : b_q;
    end

    always_comb begin
        s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
        ll_d       = ll_q;
        lh_d       = lh_q;
        hl_d       = hl_q;
        hh_d       = hh_q;
        if (s1_adv) begin
            ll_d = mul4(a_q[3:0], b_q[3:0]) & LL_MASK;
            lh_d = mul4(a_q[3:0], b_q[7:4]);
            hl_d = mul4(a_q[7:4], b_q[3:0]);
            hh_d = mul4(a_q[7:4], b_q[7:4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            s2_valid_q <= 1'b0;
            ll_q       <= 8'h00;
            lh_q       <= 8'h00;
            hl_q       <= 8'h00;
            hh_q       <= 8'h00;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s2_valid_q <= s2_valid_d;
            ll_q       <= ll_d;
            lh_q       <= lh_d;
            hl_q       <= hl_d;
            hh_q       <= hh_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign ll        = ll_q;
    assign lh        = lh_q;
    assign hl        = hl_q;
    assign hh        = hh_q;

endmodule
